// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame link: state encoding and the default
// frame geometry used by both the transmitter and the receiver.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    localparam int         SYNC_LEN_DEF  = 8;
    localparam logic [7:0] SYNC_WORD_DEF = 8'hB4;
    localparam int         DATA_W_DEF    = 6;
    localparam int         CNT_W_DEF     = 8;
    localparam int         FRAME_LEN     = SYNC_LEN_DEF + DATA_W_DEF + 1;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Bit-strobed serial input plus the parallel result bus of the frame receiver.
interface serial_frame_rx_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
);
    logic              en;
    logic              sdi;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              busy;
    logic [CNT_W-1:0]  frame_cnt;

    modport master (
        output en, sdi,
        input  data_out, data_valid, parity_err, busy, frame_cnt
    );

    modport slave (
        input  en, sdi,
        output data_out, data_valid, parity_err, busy, frame_cnt
    );
endinterface

// File: rtl/serial_sync_detect.sv
// Sync-word hunter: shifts the serial stream through a SYNC_LEN window and flags
// (combinationally) when the window including the current bit equals SYNC_WORD.
module serial_sync_detect #(
    parameter int                  SYNC_LEN  = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_shift,
    input  logic i_clear,
    input  logic i_sdi,
    output logic o_hit
);
    // Only the SYNC_LEN-1 oldest bits are stored; the live bit completes the window.
    logic [SYNC_LEN-2:0] r_sr;
    logic [SYNC_LEN-1:0] w_window;

    assign w_window = {r_sr, i_sdi};
    assign o_hit    = (w_window == SYNC_WORD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (i_clear) begin
            r_sr <= '0;
        end else if (i_shift) begin
            r_sr <= w_window[SYNC_LEN-2:0];
        end
    end
endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: locks on the sync word, shifts in an MSB-first payload,
// checks trailing even parity and publishes good payloads with a valid strobe.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int                  SYNC_LEN  = SYNC_LEN_DEF,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(SYNC_WORD_DEF),
    parameter int                  DATA_W    = DATA_W_DEF,
    parameter int                  CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_frame_rx_if.slave  bus
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e            r_state;
    logic [DATA_W-1:0] r_data_sr;
    logic [BIT_W-1:0]  r_bitcnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_parity_err;
    logic              r_busy;
    logic [CNT_W-1:0]  r_frame_cnt;

    logic w_hit;
    logic w_shift;
    logic w_clear;

    assign w_shift = bus.en && (r_state == ST_HUNT);
    assign w_clear = bus.en && (r_state == ST_PARITY);

    serial_sync_detect #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_shift (w_shift),
        .i_clear (w_clear),
        .i_sdi   (bus.sdi),
        .o_hit   (w_hit)
    );

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples pre-edge values, matching the hardware regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_HUNT;
            r_data_sr    <= '0;
            r_bitcnt     <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            // Strobes default low so they last exactly one cycle, even with en=0.
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            if (bus.en) begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_hit) begin
                            r_state  <= ST_DATA;
                            r_bitcnt <= '0;
                            r_busy   <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        r_data_sr <= DATA_W'({r_data_sr, bus.sdi});
                        r_bitcnt  <= r_bitcnt + BIT_W'(1);
                        if (r_bitcnt == BIT_W'(DATA_W - 1)) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        if (^{r_data_sr, bus.sdi} == 1'b0) begin
                            r_data_out   <= r_data_sr;
                            r_data_valid <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + CNT_W'(1);
                        end else begin
                            r_parity_err <= 1'b1;
                        end
                        r_state <= ST_HUNT;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_HUNT;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.busy       = r_busy;
    assign bus.frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: stimulus pushes expected frame results,
// a negedge monitor pops and compares on every valid or parity-error strobe.
module tb_serial_frame_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_frame_rx_if #(.DATA_W(6), .CNT_W(8)) bus ();

    serial_frame_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit         good;
        logic [5:0] data;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [5:0] exp_data = '0;
    logic [7:0] exp_cnt = '0;
    bit         gap = 1'b0;
    bit         watch_busy = 1'b0;
    bit         busy_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_bit(input logic b);
        if (gap) begin
            @(negedge clk);
            bus.en  = 1'b0;
            bus.sdi = ~b;
        end
        @(negedge clk);
        bus.en  = 1'b1;
        bus.sdi = b;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive_bit(v[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.en  = 1'b1;
            bus.sdi = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [5:0] d, input logic par);
        exp_t e;
        if ((^{d, par}) == 1'b0) begin
            exp_data = d;
            exp_cnt  = exp_cnt + 8'd1;
            e.good   = 1'b1;
        end else begin
            e.good   = 1'b0;
        end
        e.data = exp_data;
        e.cnt  = exp_cnt;
        exp_q.push_back(e);
        send_bits(16'h00B4, 8);
        send_bits({10'd0, d}, 6);
        drive_bit(par);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.en  = 1'b1;
        bus.sdi = 1'b1;
        @(negedge clk);
        rst_n   = 1'b1;
        bus.en  = 1'b0;
        bus.sdi = 1'b0;
        exp_data = '0;
        exp_cnt  = '0;
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_data_valid", 32'(bus.data_valid), 32'h0);
        check("rst_parity_err", 32'(bus.parity_err), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_frame_cnt", 32'(bus.frame_cnt), 32'h0);
    endtask

    always @(negedge clk) begin
        if (watch_busy && bus.busy === 1'b1) busy_seen = 1'b1;
        if (bus.data_valid === 1'b1 || bus.parity_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, bus.data_valid, bus.parity_err}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {30'd0, bus.data_valid, bus.parity_err},
                      e.good ? 32'h2 : 32'h1);
                check("data_out", 32'(bus.data_out), 32'(e.data));
                check("frame_cnt", 32'(bus.frame_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [5:0] d;
        bus.en  = 1'b0;
        bus.sdi = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // T1: idle then one good frame
        idle(20);
        send_frame(6'h2D, 1'b0);
        idle(1);
        check("t1_busy_after", 32'(bus.busy), 32'h0);
        check("t1_data_out", 32'(bus.data_out), 32'h2D);
        idle(2);

        // T2: bad parity, data_out and count held
        send_frame(6'h2D, 1'b1);
        idle(1);
        check("t2_busy_after", 32'(bus.busy), 32'h0);
        idle(2);

        // T3: en gated every other cycle with garbage sdi in the gaps
        gap = 1'b1;
        send_frame(6'h2D, 1'b0);
        gap = 1'b0;
        idle(2);

        // T4: near-miss sync words never lock
        busy_seen  = 1'b0;
        watch_busy = 1'b1;
        send_bits(16'h00B0, 8);
        send_bits(16'h00B5, 8);
        send_bits(16'h003F, 6);
        idle(1);
        watch_busy = 1'b0;
        check("t4_no_lock", 32'(busy_seen), 32'h0);
        send_frame(6'h34, 1'b1);
        idle(2);

        // T5: reset at payload bit 3 aborts the frame silently
        send_bits(16'h00B4, 8);
        send_bits(16'h0005, 3);
        check("t5_busy_in_frame", 32'(bus.busy), 32'h1);
        do_reset();
        send_frame(6'h2D, 1'b0);
        idle(2);

        // T6: 256 back-to-back good frames wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            d = 6'($urandom_range(0, 63));
            send_frame(d, ^d);
        end
        idle(3);
        check("t6_cnt_wrap", 32'(bus.frame_cnt), 32'h0);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
